pwm_capture: RTL and testbench

//   Memory-mapped PWM input-capture peripheral; the receive-side counterpart of the PWM output block.

---
 rtl/pwm_capture_if.sv | 10 +
 rtl/pwm_capture.sv | 194 +++++++++++++++++++
 tb/tb_pwm_capture.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// Register bus for the PWM capture peripheral: register select, write port and combinational read-back.
interface pwm_capture_if;
    logic [1:0]  A;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;

    modport master (output A, output WD, output WE, input RD);
    modport slave  (input A, input WD, input WE, output RD);
endinterface

// File: rtl/pwm_capture.sv
// PWM input capture: measures high time and period of PWM_IN in clk cycles and derives integer duty percent.
module pwm_capture #(
    parameter int CNT_W   = 24,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         PWM_IN,
    pwm_capture_if.slave bus
);

    localparam int               N_W     = CNT_W + 7;
    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE} state_t;

    state_t           state, next_state;
    logic             sync_p0, s, s_d, rise;
    logic             en, valid, stuck, tmo;
    logic             en_next, wr_ctrl;
    logic             start, capture, tmo_fire;
    logic [CNT_W-1:0] cnt, hcnt, high, period;
    logic [6:0]       duty, quo;
    logic             div_busy;
    logic [2:0]       div_step;
    logic [N_W-1:0]   rem;
    logic [CNT_W-1:0] den;
    logic [N_W:0]     div_out;
    logic             div_done;
    logic [31:0]      rd;
    logic             unused_wd;

    function automatic logic [N_W-1:0] times100(input logic [CNT_W-1:0] h);
        logic [N_W-1:0] hx;
        hx = N_W'(h);
        return (hx << 6) + (hx << 5) + (hx << 2);
    endfunction

    // One restoring step: returns {quotient bit, new remainder}.
    function automatic logic [N_W:0] div_iter(input logic [N_W-1:0] r,
                                              input logic [CNT_W-1:0] d,
                                              input logic [2:0] sh);
        logic [N_W-1:0] dsh;
        dsh = N_W'(d) << sh;
        if (r >= dsh)
            return {1'b1, r - dsh};
        return {1'b0, r};
    endfunction

    assign unused_wd = ^{bus.WD[31:4], bus.WD[2]};
    assign wr_ctrl   = bus.WE && (bus.A == 2'd0);
    assign en_next   = wr_ctrl ? bus.WD[0] : en;
    assign rise      = s & ~s_d;

    // Input synchronizer and edge-detect delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            s       <= 1'b0;
            s_d     <= 1'b0;
        end else begin
            sync_p0 <= PWM_IN;
            s       <= sync_p0;
            s_d     <= s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Clearing EN overrides everything else, so nothing is captured on that cycle.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        capture    = 1'b0;
        tmo_fire   = 1'b0;
        case (state)
            IDLE: if (en) next_state = WAIT_RISE;
            WAIT_RISE: begin
                if (cnt == TMO_CNT) tmo_fire = 1'b1;
                else if (rise) begin
                    start      = 1'b1;
                    next_state = MEASURE;
                end
            end
            MEASURE: begin
                if (cnt == TMO_CNT) begin
                    tmo_fire   = 1'b1;
                    next_state = WAIT_RISE;
                end else if (rise) capture = 1'b1;
            end
            default: next_state = IDLE;
        endcase
        if (!en_next) begin
            next_state = IDLE;
            start      = 1'b0;
            capture    = 1'b0;
            tmo_fire   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            hcnt <= '0;
        end else if (state == IDLE || !en_next || tmo_fire) begin
            cnt  <= '0;
            hcnt <= '0;
        end else if (start || capture) begin
            cnt  <= CNT_W'(1);
            hcnt <= CNT_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
            if (state == MEASURE) hcnt <= hcnt + CNT_W'(s);
        end
    end

    assign div_out  = div_iter(rem, den, div_step - 3'd1);
    assign div_done = div_busy && (div_step == 3'd0) && en_next && !tmo_fire && !capture;

    // A new capture always reloads the divider, so only the newest measurement reaches DUTY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high     <= '0;
            period   <= '0;
            stuck    <= 1'b0;
            duty     <= '0;
            div_busy <= 1'b0;
            div_step <= '0;
            rem      <= '0;
            den      <= '0;
            quo      <= '0;
        end else begin
            if (capture) begin
                high   <= hcnt;
                period <= cnt;
            end else if (tmo_fire) begin
                high   <= '0;
                period <= '0;
                stuck  <= s;
                duty   <= s ? 7'd100 : 7'd0;
            end
            if (!en_next || tmo_fire) begin
                div_busy <= 1'b0;
            end else if (capture) begin
                div_busy <= 1'b1;
                div_step <= 3'd7;
                rem      <= times100(hcnt);
                den      <= cnt;
                quo      <= '0;
            end else if (div_busy) begin
                if (div_step != 3'd0) begin
                    rem      <= div_out[N_W-1:0];
                    quo      <= {quo[5:0], div_out[N_W]};
                    div_step <= div_step - 3'd1;
                end else begin
                    div_busy <= 1'b0;
                    duty     <= quo;
                end
            end
        end
    end

    // Hardware set beats a same-cycle write-one-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en    <= 1'b0;
            valid <= 1'b0;
            tmo   <= 1'b0;
        end else begin
            en <= en_next;
            if (tmo_fire || div_done)      valid <= 1'b1;
            else if (wr_ctrl && bus.WD[1]) valid <= 1'b0;
            if (tmo_fire)                  tmo <= 1'b1;
            else if (wr_ctrl && bus.WD[3]) tmo <= 1'b0;
        end
    end

    always_comb begin
        rd = '0;
        case (bus.A)
            2'd0: rd = {28'd0, tmo, stuck, valid, en};
            2'd1: rd = 32'(high);
            2'd2: rd = 32'(period);
            2'd3: rd = 32'(duty);
            default: rd = '0;
        endcase
    end

    assign bus.RD = rd;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: random PWM segments scored against an edge-level reference, plus directed corner cases.
module tb_pwm_capture;

    localparam int CNT_W = 24;
    localparam int TMO   = 1500;

    typedef struct {int high; int low;} seg_t;
    typedef struct {int h; int p; int d;} exp_t;

    logic clk = 1'b0;
    logic rst;
    logic pwm = 1'b0;
    int   cyc = 0;

    pwm_capture_if bus ();

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .clk    (clk),
        .rst    (rst),
        .PWM_IN (pwm),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg_t seg_arr [0:511];
    exp_t exp_arr [0:511];
    int   seg_pushed = 0, seg_done = 0;
    int   exp_wr = 0, exp_rd = 0;
    int   rise_n = 0, rise_cyc = 0;
    bit   model_on = 1'b0;
    int   errors = 0, checks = 0;
    exp_t last_exp;

    // Stimulus: plays each segment (high cycles then low cycles); every rising edge closes the
    // previous period, whose result survives only if the next capture is at least 9 cycles away.
    initial begin
        seg_t sg;
        bit   have_prev;
        int   prev_h, prev_len;
        have_prev = 1'b0;
        prev_h    = 0;
        prev_len  = 1;
        forever begin
            @(negedge clk);
            if (seg_done < seg_pushed) begin
                sg = seg_arr[seg_done];
                if (sg.high > 0 && pwm == 1'b0) begin
                    if (model_on && have_prev &&
                        !((sg.high + sg.low) < 9 && seg_done + 1 < seg_pushed)) begin
                        exp_arr[exp_wr] = '{prev_h, prev_len, (prev_h * 100) / prev_len};
                        exp_wr++;
                    end
                    have_prev = model_on;
                    prev_h    = sg.high;
                    prev_len  = sg.high + sg.low;
                    rise_cyc  = cyc;
                    rise_n++;
                end
                if (sg.high > 0) begin
                    pwm = 1'b1;
                    repeat (sg.high - 1) @(negedge clk);
                end
                if (sg.low > 0) begin
                    if (sg.high > 0) @(negedge clk);
                    pwm = 1'b0;
                    repeat (sg.low - 1) @(negedge clk);
                end
                seg_done++;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.A = a;
        #1;
        d = bus.RD;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.A  = a;
        bus.WD = d;
        bus.WE = 1'b1;
        @(negedge clk);
        bus.WE = 1'b0;
    endtask

    task automatic push(input int h, input int l);
        seg_arr[seg_pushed] = '{h, l};
        seg_pushed++;
    endtask

    task automatic wait_stim(input string nm);
        int g = 0;
        while (seg_done < seg_pushed && g < 8 * TMO) begin
            @(negedge clk);
            g++;
        end
        check(nm, 32'(seg_done >= seg_pushed), 1);
    endtask

    task automatic wait_rises(input int n, input string nm);
        int g = 0;
        while (rise_n < n && g < 8 * TMO) begin
            @(negedge clk);
            g++;
        end
        check(nm, 32'(rise_n >= n), 1);
    endtask

    // Monitor: whenever VALID is up, pop the oldest expectation, compare, and clear VALID.
    task automatic run_monitor(input int quiet_need);
        int          quiet = 0, guard = 0;
        logic [31:0] c, h, p, d;
        exp_t        e;
        while (guard < 30000 && !(seg_done == seg_pushed && quiet >= quiet_need)) begin
            @(negedge clk);
            bus.WE = 1'b0;
            guard++;
            quiet++;
            rd(2'd0, c);
            if (c[1]) begin
                quiet = 0;
                rd(2'd1, h);
                rd(2'd2, p);
                rd(2'd3, d);
                if (exp_rd < exp_wr) begin
                    e = exp_arr[exp_rd];
                    exp_rd++;
                    check("high", h, e.h);
                    check("period", p, e.p);
                    check("duty", d, e.d);
                    last_exp = e;
                end else begin
                    check("unexpected_valid", c, 0);
                end
                bus.A  = 2'd0;
                bus.WD = 32'h3;
                bus.WE = 1'b1;
            end
        end
        @(negedge clk);
        bus.WE = 1'b0;
        check("monitor_budget", 32'(guard < 30000), 1);
        check("sb_leftover", exp_wr - exp_rd, 0);
    endtask

    initial begin
        logic [31:0] v;
        int          len, hi, base, g;
        bus.A  = 2'd0;
        bus.WD = '0;
        bus.WE = 1'b0;
        rst    = 1'b1;
        repeat (2) @(negedge clk);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            check("reset_rd", v, 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Scoreboarded measurement: fixed duty cases, random periods, then a short-period burst.
        wr(2'd0, 32'h1);
        repeat (4) @(negedge clk);
        model_on = 1'b1;
        for (int i = 0; i < 3; i++) push(250, 750);
        for (int i = 0; i < 2; i++) push(333, 667);
        for (int i = 0; i < 2; i++) push(999, 1);
        for (int i = 0; i < 20; i++) begin
            len = $urandom_range(12, 300);
            hi  = $urandom_range(1, len - 1);
            push(hi, len - hi);
        end
        push(2, 3); push(1, 1); push(4, 4); push(3, 5);
        push(20, 20); push(20, 20);
        run_monitor(30);

        // Disable mid-period: old results stay readable, and re-enable needs two rises.
        wr(2'd0, 32'h0);
        model_on = 1'b0;
        rd(2'd0, v); check("dis_ctrl", v, 0);
        rd(2'd1, v); check("dis_high", v, last_exp.h);
        rd(2'd2, v); check("dis_period", v, last_exp.p);
        rd(2'd3, v); check("dis_duty", v, last_exp.d);
        push(30, 30);
        wait_stim("dis_drain");
        wr(2'd0, 32'h1);
        repeat (4) @(negedge clk);
        model_on = 1'b1;
        push(40, 60); push(40, 60); push(10, 10);
        run_monitor(30);

        // Stuck high, then stuck low.
        wr(2'd0, 32'hA);
        model_on = 1'b0;
        push(TMO + 60, 0);
        push(0, 2 * TMO + 100);
        repeat (20) @(negedge clk);
        wr(2'd0, 32'h1);
        repeat (TMO + 20) @(negedge clk);
        rd(2'd0, v); check("stuck1_ctrl", v, 32'hF);
        rd(2'd1, v); check("stuck1_high", v, 0);
        rd(2'd2, v); check("stuck1_period", v, 0);
        rd(2'd3, v); check("stuck1_duty", v, 100);
        wr(2'd0, 32'hB);
        rd(2'd0, v); check("w1c_idle_ctrl", v, 32'h5);
        repeat (TMO + 20) @(negedge clk);
        rd(2'd0, v); check("stuck0_ctrl", v, 32'hB);
        rd(2'd3, v); check("stuck0_duty", v, 0);
        wr(2'd0, 32'hA);
        wait_stim("stuck_drain");

        // W1C of VALID on the exact cycle the divide completes (8 clk after the capture).
        wr(2'd0, 32'h1);
        repeat (4) @(negedge clk);
        base = rise_n;
        push(50, 50); push(50, 50); push(10, 10);
        wait_rises(base + 2, "race_rise");
        g = 0;
        while (cyc < rise_cyc + 10 && g < 50) begin
            @(negedge clk);
            g++;
        end
        rd(2'd0, v); check("pre_done_ctrl", v, 32'h1);
        bus.A  = 2'd0;
        bus.WD = 32'h3;
        bus.WE = 1'b1;
        @(negedge clk);
        bus.WE = 1'b0;
        rd(2'd0, v); check("w1c_race_ctrl", v, 32'h3);
        rd(2'd3, v); check("race_duty", v, 50);
        repeat (3) @(negedge clk);
        wr(2'd0, 32'h3);
        rd(2'd0, v); check("w1c_idle_valid", v, 32'h1);

        // Reset in the middle of a divide.
        wait_rises(base + 3, "rst_rise");
        g = 0;
        while (cyc < rise_cyc + 6 && g < 50) begin
            @(negedge clk);
            g++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            check("midrst_rd", v, 0);
        end
        repeat (15) @(negedge clk);
        rd(2'd3, v); check("late_duty", v, 0);
        rd(2'd0, v); check("late_ctrl", v, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
